// File: rtl/matrix_inverse_2x2_fx_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_inverse_2x2_fx_if
// Purpose  : Request/result bundle for the 2x2 fixed-point matrix inverter.
//            The master side issues start with a matrix A. The slave side
//            returns Res together with the busy/done/singular/saturated status.
// Signals  : start     - request an inversion (level, sampled in IDLE)
//            A         - input matrix, WIDTH-bit signed elements [row][col]
//            Res       - inverse matrix, same format as A
//            busy      - operation in progress
//            done      - result valid strobe (one enabled cycle)
//            singular  - determinant of the last operand was zero
//            saturated - at least one result element was clipped
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_inverse_2x2_fx_if #(
    parameter int WIDTH = 16
);
    logic                         start;
    logic [0:1][0:1][WIDTH-1:0]   A;
    logic [0:1][0:1][WIDTH-1:0]   Res;
    logic                         busy;
    logic                         done;
    logic                         singular;
    logic                         saturated;

    modport master (
        output start, A,
        input  Res, busy, done, singular, saturated
    );

    modport slave (
        input  start, A,
        output Res, busy, done, singular, saturated
    );
endinterface
`default_nettype wire

// File: rtl/matrix_inverse_2x2_fx.sv
`default_nettype none
// ============================================================================
// Module   : matrix_inverse_2x2_fx
// Purpose  : Signed fixed-point 2x2 matrix inverse, inv(A) = adj(A) / det(A).
//            A single restoring divider is shared by the four elements, one
//            quotient bit per enabled cycle. Zero determinants are flagged as
//            singular, and results outside the WIDTH-bit range saturate.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset, overrides clk_en
//            clk_en - global enable; all registers hold while low
//            bus    - slave modport: start/A in, Res/busy/done/singular/
//                     saturated out
// Revision : 1.0 - initial release
// ============================================================================
module matrix_inverse_2x2_fx #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clk_en,
    matrix_inverse_2x2_fx_if.slave    bus
);

    localparam int c_DW = 2*WIDTH + 1;          // determinant width
    localparam int c_AW = WIDTH + 1;            // adjugate element width
    localparam int c_QW = WIDTH + 2*FRAC;       // quotient width / divide cycles
    localparam int c_CW = $clog2(c_QW);

    localparam logic [WIDTH-1:0] c_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_MAX     = ~c_MIN;
    localparam logic [c_QW-1:0]  c_NEG_LIM = c_QW'(1) << (WIDTH-1);
    localparam logic [c_QW-1:0]  c_POS_LIM = c_NEG_LIM - c_QW'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DET   = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_DIV   = 3'd3;
    localparam logic [2:0] c_ST_STORE = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]                   r_state;
    logic [0:1][0:1][WIDTH-1:0]   r_al;
    logic signed [c_DW-1:0]       r_det;
    logic [1:0]                   r_k;
    logic [c_QW-1:0]              r_num;
    logic [c_DW-1:0]              r_den;
    logic [c_DW-1:0]              r_rem;
    logic [c_QW-1:0]              r_quo;
    logic [c_CW-1:0]              r_cnt;
    logic                         r_neg;
    logic [0:1][0:1][WIDTH-1:0]   r_res;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_singular;
    logic                         r_saturated;

    // Determinant in Q(2*FRAC); operands sign-extended so the products are exact.
    logic signed [c_DW-1:0] w_a00, w_a01, w_a10, w_a11, w_det;
    assign w_a00 = c_DW'($signed(r_al[0][0]));
    assign w_a01 = c_DW'($signed(r_al[0][1]));
    assign w_a10 = c_DW'($signed(r_al[1][0]));
    assign w_a11 = c_DW'($signed(r_al[1][1]));
    assign w_det = w_a00 * w_a11 - w_a01 * w_a10;

    // Adjugate element for slot k, one bit wider so negating the most
    // negative input cannot overflow.
    logic signed [c_AW-1:0] w_adj;
    always_comb begin
        w_adj = '0;
        case (r_k)
            2'd0:    w_adj =   c_AW'($signed(r_al[1][1]));
            2'd1:    w_adj = -(c_AW'($signed(r_al[0][1])));
            2'd2:    w_adj = -(c_AW'($signed(r_al[1][0])));
            default: w_adj =   c_AW'($signed(r_al[0][0]));
        endcase
    end

    // |adj| <= 2^(WIDTH-1), so the magnitude fits in WIDTH unsigned bits.
    logic [WIDTH-1:0] w_adj_mag;
    logic [c_QW-1:0]  w_num;
    logic [c_DW-1:0]  w_den;
    assign w_adj_mag = w_adj[c_AW-1] ? WIDTH'(-w_adj) : w_adj[WIDTH-1:0];
    assign w_num     = c_QW'(w_adj_mag) << (2*FRAC);
    assign w_den     = r_det[c_DW-1] ? c_DW'(-r_det) : c_DW'(r_det);

    // Restoring step. |det| < 2^(c_DW-1), so the trial remainder never reaches
    // its top bit, and the MSB of the difference is a clean borrow flag.
    logic [c_DW:0] w_trial, w_sub;
    assign w_trial = {r_rem, r_num[c_QW-1]};
    assign w_sub   = w_trial - {1'b0, r_den};

    // Sign application with truncation toward zero, then clipping to range.
    logic [WIDTH-1:0] w_store;
    logic             w_clip;
    always_comb begin
        w_clip  = 1'b0;
        w_store = r_quo[WIDTH-1:0];
        if (r_neg) begin
            if (r_quo > c_NEG_LIM) begin
                w_clip  = 1'b1;
                w_store = c_MIN;
            end else begin
                w_store = -r_quo[WIDTH-1:0];
            end
        end else if (r_quo > c_POS_LIM) begin
            w_clip  = 1'b1;
            w_store = c_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_al        <= '0;
            r_det       <= '0;
            r_k         <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_res       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_singular  <= 1'b0;
            r_saturated <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_al        <= bus.A;
                        r_singular  <= 1'b0;
                        r_saturated <= 1'b0;
                        r_k         <= 2'd0;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_DET;
                    end
                end
                c_ST_DET: begin
                    r_det <= w_det;
                    if (w_det == '0) begin
                        r_singular <= 1'b1;
                        r_res      <= '0;
                        r_done     <= 1'b1;
                        r_state    <= c_ST_DONE;
                    end else begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_num   <= w_num;
                    r_den   <= w_den;
                    r_neg   <= w_adj[c_AW-1] ^ r_det[c_DW-1];
                    r_rem   <= '0;
                    r_quo   <= '0;
                    r_cnt   <= c_CW'(c_QW - 1);
                    r_state <= c_ST_DIV;
                end
                c_ST_DIV: begin
                    if (!w_sub[c_DW]) begin
                        r_rem <= w_sub[c_DW-1:0];
                    end else begin
                        r_rem <= w_trial[c_DW-1:0];
                    end
                    r_quo <= {r_quo[c_QW-2:0], ~w_sub[c_DW]};
                    r_num <= r_num << 1;
                    if (r_cnt == '0) begin
                        r_state <= c_ST_STORE;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                c_ST_STORE: begin
                    r_res[r_k[1]][r_k[0]] <= w_store;
                    if (w_clip) begin
                        r_saturated <= 1'b1;
                    end
                    if (r_k == 2'd3) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Res       = r_res;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.singular  = r_singular;
    assign bus.saturated = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_matrix_inverse_2x2_fx.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_inverse_2x2_fx
// Purpose  : Directed self-checking bench for matrix_inverse_2x2_fx using
//            hand-computed inverses in Q8.8 (WIDTH=16, FRAC=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_inverse_2x2_fx;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int QW    = WIDTH + 2*FRAC;
    localparam int LAT   = 4*QW + 10;       // 138 enabled cycles, start to done

    typedef logic [0:1][0:1][WIDTH-1:0] mat_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    always #5 clk = ~clk;

    matrix_inverse_2x2_fx_if #(.WIDTH(WIDTH)) bus ();

    matrix_inverse_2x2_fx #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mat_t mk(input int a00, input int a01, input int a10, input int a11);
        mat_t m;
        m[0][0] = a00[WIDTH-1:0];
        m[0][1] = a01[WIDTH-1:0];
        m[1][0] = a10[WIDTH-1:0];
        m[1][1] = a11[WIDTH-1:0];
        return m;
    endfunction

    // One inversion. rand_en toggles clk_en, restart pulses start mid-run,
    // abort_at > 0 applies rst (with clk_en low) after that many enabled edges.
    task automatic run_op(input string tag, input mat_t a,
                          input int e00, input int e01, input int e10, input int e11,
                          input int e_lat, input bit e_sing, input bit e_sat,
                          input bit rand_en, input bit restart, input int abort_at);
        int n_en;
        int busy_cnt;
        int busy_gap;
        int frozen;
        int guard;
        logic [4*WIDTH+3:0] snap;
        mat_t res_done;

        @(negedge clk);
        bus.A     = a;
        bus.start = 1'b1;
        clk_en    = 1'b1;
        @(posedge clk);                       // accept edge
        n_en = 1; busy_cnt = 0; busy_gap = 0; frozen = 0; guard = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = mk(-1234, 77, 4321, -5);  // only the latched copy may matter
        if (bus.busy) busy_cnt++; else busy_gap++;

        while (!bus.done && guard < 5000 && !(abort_at > 0 && n_en >= abort_at)) begin
            guard++;
            clk_en    = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.start = restart && (n_en == 20);
            snap = {bus.Res, bus.busy, bus.done, bus.singular, bus.saturated};
            @(posedge clk);
            @(negedge clk);
            if (clk_en) begin
                n_en++;
                if (bus.busy) busy_cnt++; else busy_gap++;
            end else if (snap != {bus.Res, bus.busy, bus.done, bus.singular, bus.saturated}) begin
                frozen++;
            end
        end
        bus.start = 1'b0;

        if (abort_at > 0) begin
            rst    = 1'b1;
            clk_en = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_rst_res"},  bus.Res,       0);
            check({tag, "_rst_busy"}, bus.busy,      0);
            check({tag, "_rst_done"}, bus.done,      0);
            check({tag, "_rst_sing"}, bus.singular,  0);
            check({tag, "_rst_sat"},  bus.saturated, 0);
            rst    = 1'b0;
            clk_en = 1'b1;
        end else begin
            check({tag, "_timeout"}, guard >= 5000, 0);
            check({tag, "_latency"}, n_en, e_lat);
            check({tag, "_busy_cycles"}, busy_cnt, e_lat);
            check({tag, "_busy_gap"}, busy_gap, 0);
            if (rand_en) check({tag, "_frozen"}, frozen, 0);
            check({tag, "_r00"}, longint'($signed(bus.Res[0][0])), e00);
            check({tag, "_r01"}, longint'($signed(bus.Res[0][1])), e01);
            check({tag, "_r10"}, longint'($signed(bus.Res[1][0])), e10);
            check({tag, "_r11"}, longint'($signed(bus.Res[1][1])), e11);
            check({tag, "_singular"},  bus.singular,  e_sing);
            check({tag, "_saturated"}, bus.saturated, e_sat);
            // Next enabled edge returns to IDLE; the result must stay put.
            res_done = bus.Res;
            clk_en   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_idle_done"}, bus.done, 0);
            check({tag, "_idle_busy"}, bus.busy, 0);
            check({tag, "_idle_res_stable"}, bus.Res == res_done, 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_res",       bus.Res,       0);
        check("reset_busy",      bus.busy,      0);
        check("reset_done",      bus.done,      0);
        check("reset_singular",  bus.singular,  0);
        check("reset_saturated", bus.saturated, 0);
        rst    = 1'b0;
        clk_en = 1'b1;

        // identity: inverse is identity
        run_op("c1_ident", mk(256, 0, 0, 256), 256, 0, 0, 256, LAT, 0, 0, 0, 0, 0);
        // det = -131072 (Q16), inverse = [[-2,1],[1.5,-0.5]]
        run_op("c2_gen", mk(256, 512, 768, 1024), -512, 256, 384, -128, LAT, 0, 0, 0, 0, 0);
        // 1/3 = 85.33 LSB, truncated toward zero
        run_op("c2_trunc", mk(768, 0, 0, 768), 85, 0, 0, 85, LAT, 0, 0, 0, 0, 0);
        // det = 0 -> singular after 2 cycles, earlier non-zero Res cleared
        run_op("c3_sing", mk(256, 512, 512, 1024), 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        // 1/(1/256) = 65536 LSB, clips positive
        run_op("c4_sat_pos", mk(1, 0, 0, 1), 32767, 0, 0, 32767, LAT, 0, 1, 0, 0, 0);
        // det = -1: Res00 = -65536 clips to -32768, Res11 = +65536 clips to 32767
        run_op("c4_sat_neg", mk(-1, 0, 0, 1), -32768, 0, 0, 32767, LAT, 0, 1, 0, 0, 0);
        // gated clock plus an ignored mid-run start
        run_op("c5_clken", mk(256, 0, 0, 256), 256, 0, 0, 256, LAT, 0, 0, 1, 1, 0);
        // reset aborts a run after Res00 has been written
        run_op("c6_abort", mk(256, 512, 768, 1024), 0, 0, 0, 0, 0, 0, 0, 0, 0, 50);
        run_op("c6_rerun", mk(256, 512, 768, 1024), -512, 256, 384, -128, LAT, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_inverse_2x2_fx.md
Name: matrix_inverse_2x2_fx

Overview:
Parametrised signed fixed-point 2x2 matrix inverter for the Kalman filter datapath. It is the next generation of the 2x2 inverter. It replaces the vendor divider IP with an in-house shared restoring divider, and it adds a programmable fractional-bit format, singular-matrix detection, output saturation, synchronous reset and a busy/done handshake. It sits between the covariance update and the Kalman gain multiply.

Parameters:
WIDTH, 16, total bits of each signed element, two's complement (input and output)
FRAC, 8, fractional bits of the Q format; 1.0 = 2^FRAC; legal range 0..WIDTH-1

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset; overrides clk_en
clk_en  in  1  global enable; when low, every register holds its value
start  in  1  request inversion; sampled only in IDLE while clk_en=1
A  in  WIDTH x [0:1][0:1]  input matrix, signed Q(WIDTH-FRAC).FRAC; latched when start is accepted
Res  out  WIDTH x [0:1][0:1]  inverse matrix, same format as A
busy  out  1  high whenever state != IDLE
done  out  1  high exactly while state == DONE
singular  out  1  determinant was zero on the last operation; valid from DONE until the next accepted start
saturated  out  1  at least one element of the last result was clipped; valid from DONE until the next accepted start

Behaviour:
- Reset (synchronous) forces state=IDLE, Res all 0, busy=0, done=0, singular=0, saturated=0. Reset mid-operation aborts the operation; all of these values are visible after that clock edge.
- Register updates occur only on edges where clk_en=1. Cycle counts below are enabled cycles.
- State machine and transitions:
  - IDLE -> DET when start=1. On that edge, latch A into Al, clear singular and saturated, and set k=0.
  - DET: det = Al00*Al11 - Al01*Al10, registered at full 2*WIDTH+1 bit signed width, in Q(2*FRAC). Go to DONE with singular=1 if det==0, otherwise go to LOAD.
  - LOAD: select adj[k]; k=0,1,2,3 select Al11, -Al01, -Al10, Al00, written to Res00, Res01, Res10, Res11 respectively.
    - Form the negation at WIDTH+1 bits, so that -(-2^(WIDTH-1)) is exact.
    - Numerator magnitude N = |adj[k]| << 2*FRAC. Divisor D = |det|. Result sign = sign(adj[k]) XOR sign(det).
    - Go to DIV.
  - DIV: restoring division, one quotient bit per cycle, QW = WIDTH+2*FRAC cycles (bits from MSB down). Go to STORE.
  - STORE: apply the sign and truncate toward zero. Saturate: a positive value > 2^(WIDTH-1)-1 gives 2^(WIDTH-1)-1; a negative value with magnitude > 2^(WIDTH-1) gives -2^(WIDTH-1). Set saturated if clipping occurred. Write Res[k]. Go to LOAD with k+1 if k<3, otherwise go to DONE.
  - DONE: done=1 for one enabled cycle. Go to IDLE.
- Res:
  - Holds its previous values until each STORE overwrites it.
  - On singular, all four elements are cleared to 0 on entry to DONE.
  - Res is stable while done=1 and while in IDLE.
- Latency (start-accept edge to the first cycle with done=1):
  - Non-singular: 4*QW+10 cycles; 138 cycles for the defaults.
  - Singular: 2 cycles.
- start while busy=1 is ignored; it is not queued. A start coinciding with the DONE cycle is ignored. start is a level, so a held start re-triggers from IDLE.
- A may change freely after the accept edge; only Al is used.

Test Plan:
1. Defaults. A=[[256,0],[0,256]], start for 1 cycle -> done 138 cycles later, Res=[[256,0],[0,256]], singular=0, saturated=0, busy high for 139 cycles.
2. A=[[256,512],[768,1024]] (det=-131072) -> Res=[[-512,256],[384,-128]], saturated=0. Follow with A=[[768,0],[0,768]] -> Res=[[85,0],[0,85]] (truncation toward zero).
3. A=[[256,512],[512,1024]] -> done 2 cycles after start, singular=1, Res all 0. Run a previous non-zero result first to confirm it is cleared.
4. A=[[1,0],[0,1]] -> Res=[[32767,0],[0,32767]], saturated=1. A=[[-1,0],[0,1]] -> Res00=-32768, Res11=32767, saturated=1.
5. Case-1 matrix with clk_en toggled pseudo-randomly -> done after exactly 138 enabled cycles; outputs frozen while clk_en=0. A second start pulse mid-operation -> ignored; the result equals that of case 1.
6. rst asserted at enabled cycle 50 of a case-2 run -> next edge gives state IDLE and Res, busy, done, singular, saturated all 0. A fresh start afterwards completes normally with the case-2 result.
